// File: rtl/sm3_pkg.sv
// Shared constants and word-level helpers for the SM3 compression datapath.
package sm3_pkg;

    localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [31:0]  T_LO = 32'h79cc4519;
    localparam logic [31:0]  T_HI = 32'h7a879d8a;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl32(x, 5'd15) ^ rotl32(x, 5'd23);
    endfunction

    function automatic logic [31:0] ff_j(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z, input logic hi);
        return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
    endfunction

    function automatic logic [31:0] gg_j(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z, input logic hi);
        return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
    endfunction

endpackage

// File: rtl/sm3_cf_pipe_round.sv
// One combinational SM3 round; state packed as {A,B,C,D,E,F,G,H}, A in the top word.
module sm3_round
    import sm3_pkg::*;
(
    input  logic [255:0] st,
    input  logic [31:0]  w,
    input  logic [31:0]  w_p,
    input  logic [5:0]   k,
    output logic [255:0] st_nxt
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t, a12, ss1, ss2, tt1, tt2;
    logic        hi;

    assign {a, b, c, d, e, f, g, h} = st;
    assign hi  = (k[5:4] != 2'b00);
    assign t   = hi ? T_HI : T_LO;
    assign a12 = rotl32(a, 5'd12);
    assign ss1 = rotl32(a12 + e + rotl32(t, k[4:0]), 5'd7);
    assign ss2 = ss1 ^ a12;
    assign tt1 = ff_j(a, b, c, hi) + d + ss2 + w_p;
    assign tt2 = gg_j(e, f, g, hi) + h + ss1 + w;

    assign st_nxt = {tt1, a, rotl32(b, 5'd9), c, p0(tt2), e, rotl32(f, 5'd19), g};

endmodule

// File: rtl/sm3_cf_pipe.sv
// SM3 compression function, RPC rounds per clock, with internal chaining value.
// state | meaning
// IDLE  | waiting for a block, in_ready high
// ROUND | applying RPC rounds per cycle, j advances by RPC
// DONE  | result registered, out_valid pulse
module sm3_cf_pipe
    import sm3_pkg::*;
#(
    parameter int RPC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         first,
    input  logic [511:0] B,
    output logic         out_valid,
    output logic [255:0] V_out,
    output logic         busy
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
        $error("sm3_cf_pipe: RPC must be 1, 2 or 4");
    end

    localparam logic [5:0] LAST = 6'(64 - RPC);

    logic [1:0]   state;
    logic [5:0]   j;
    logic [31:0]  win [16];
    logic [31:0]  nw  [RPC];
    logic [255:0] cas [RPC+1];
    logic [255:0] st, v_init, v_chain, v_start;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign v_start  = first ? IV : v_chain;
    assign cas[0]   = st;

    for (genvar i = 0; i < RPC; i++) begin : g_round
        sm3_round u_round (
            .st     (cas[i]),
            .w      (win[i]),
            .w_p    (win[i] ^ win[i+4]),
            .k      (j + 6'(i)),
            .st_nxt (cas[i+1])
        );
    end

    // With RPC=4 the last new word depends on the first one produced this cycle.
    for (genvar m = 0; m < RPC; m++) begin : g_exp
        logic [31:0] w3;
        if (m < 3) begin : g_win
            assign w3 = win[13+m];
        end else begin : g_new
            assign w3 = nw[m-3];
        end
        assign nw[m] = p1(win[m] ^ win[7+m] ^ rotl32(w3, 5'd15))
                       ^ rotl32(win[3+m], 5'd7) ^ win[10+m];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            j         <= '0;
            out_valid <= 1'b0;
            V_out     <= '0;
            v_chain   <= IV;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= ROUND;
                        j     <= '0;
                    end
                end
                ROUND: begin
                    j <= j + 6'(RPC);
                    if (j == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        V_out     <= cas[RPC] ^ v_init;
                        v_chain   <= cas[RPC] ^ v_init;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            for (int i = 0; i < 16; i++) win[i] <= B[511-32*i -: 32];
            v_init <= v_start;
            st     <= v_start;
        end else if (state == ROUND) begin
            for (int i = 0; i < 16 - RPC; i++) win[i] <= win[i+RPC];
            for (int m = 0; m < RPC; m++) win[16-RPC+m] <= nw[m];
            st <= cas[RPC];
        end
    end

endmodule

// File: tb/tb_sm3_cf_pipe.sv
// Directed bench for sm3_cf_pipe with RPC = 1, 2 and 4 instances side by side.
module tb_sm3_cf_pipe;

    localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_ABCD = {16{32'h61626364}};
    localparam logic [511:0] BLK_PAD  = {32'h80000000, 448'h0, 32'h00000200};
    localparam logic [255:0] DIG_ABC  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] DIG_TWO  = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         first     [3];
    logic [511:0] B         [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [255:0] V_out     [3];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    sm3_cf_pipe #(.RPC(1)) u_rpc1 (.clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .first(first[0]), .B(B[0]), .out_valid(out_valid[0]), .V_out(V_out[0]), .busy(busy[0]));
    sm3_cf_pipe #(.RPC(2)) u_rpc2 (.clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .first(first[1]), .B(B[1]), .out_valid(out_valid[1]), .V_out(V_out[1]), .busy(busy[1]));
    sm3_cf_pipe #(.RPC(4)) u_rpc4 (.clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .first(first[2]), .B(B[2]), .out_valid(out_valid[2]), .V_out(V_out[2]), .busy(busy[2]));

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called and returning on a negedge; returns at the negedge where out_valid is seen.
    task automatic send(input int r, input logic f, input logic [511:0] blk, input logic noise,
                        output int lat, output logic [255:0] v);
        int t;
        string pfx;
        pfx = $sformatf("rpc%0d", 1 << r);
        in_valid[r] = 1'b1;
        first[r]    = f;
        B[r]        = blk;
        t = 0;
        while (!in_ready[r] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check({pfx, " accept timeout"}, 256'(0), 256'(1));
        @(negedge clk);
        in_valid[r] = 1'b0;
        lat = 1;
        while (!out_valid[r] && lat < 200) begin
            if (lat == 2) begin
                check({pfx, " busy in round"}, 256'(busy[r]), 256'(1));
                check({pfx, " in_ready in round"}, 256'(in_ready[r]), 256'(0));
            end
            if (noise) begin
                in_valid[r] = lat[0];
                B[r] = {16{$urandom}};
                first[r] = ~first[r];
            end
            @(negedge clk);
            lat++;
        end
        in_valid[r] = 1'b0;
        if (lat >= 200) check({pfx, " out_valid timeout"}, 256'(0), 256'(1));
        v = V_out[r];
    endtask

    initial begin
        int lat;
        logic [255:0] v;
        for (int r = 0; r < 3; r++) begin
            in_valid[r] = 1'b0;
            first[r]    = 1'b0;
            B[r]        = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 3; r++) begin
            check($sformatf("rpc%0d reset in_ready", 1 << r), 256'(in_ready[r]), 256'(1));
            check($sformatf("rpc%0d reset busy", 1 << r), 256'(busy[r]), 256'(0));
            check($sformatf("rpc%0d reset out_valid", 1 << r), 256'(out_valid[r]), 256'(0));
            check($sformatf("rpc%0d reset V_out", 1 << r), V_out[r], 256'(0));
        end

        for (int r = 0; r < 3; r++) begin
            int rpc, p, n_acc, n_out, last_acc, ov_seen;
            string pfx;
            rpc = 1 << r;
            p   = 64 / rpc + 2;
            pfx = $sformatf("rpc%0d", rpc);

            send(r, 1'b1, BLK_ABC, 1'b0, lat, v);
            check({pfx, " abc digest"}, v, DIG_ABC);
            check({pfx, " abc latency"}, 256'(lat), 256'(64 / rpc + 1));

            send(r, 1'b1, BLK_ABCD, 1'b0, lat, v);
            send(r, 1'b0, BLK_PAD, 1'b0, lat, v);
            check({pfx, " two-block digest"}, v, DIG_TWO);

            send(r, 1'b1, BLK_ABC, 1'b1, lat, v);
            check({pfx, " busy-ignore digest"}, v, DIG_ABC);

            // Back-to-back with in_valid held high.
            @(negedge clk);
            in_valid[r] = 1'b1;
            first[r]    = 1'b1;
            B[r]        = BLK_ABC;
            n_acc = 0;
            n_out = 0;
            last_acc = 0;
            for (int c = 0; c < 3 * p; c++) begin
                if (in_ready[r]) begin
                    if (n_acc > 0) check({pfx, " b2b spacing"}, 256'(c - last_acc), 256'(p));
                    last_acc = c;
                    n_acc++;
                end
                if (c == 1) check({pfx, " b2b in_ready low"}, 256'(in_ready[r]), 256'(0));
                if (out_valid[r]) begin
                    n_out++;
                    check({pfx, " b2b digest"}, V_out[r], DIG_ABC);
                end
                @(negedge clk);
            end
            in_valid[r] = 1'b0;
            check({pfx, " b2b accepts"}, 256'(n_acc), 256'(3));
            check({pfx, " b2b results"}, 256'(n_out), 256'(3));

            // Reset at j=32, then first=0 must fall back to the IV.
            @(negedge clk);
            in_valid[r] = 1'b1;
            first[r]    = 1'b1;
            B[r]        = BLK_ABCD;
            @(negedge clk);
            in_valid[r] = 1'b0;
            ov_seen = 0;
            for (int c = 0; c < 32 / rpc; c++) begin
                if (out_valid[r]) ov_seen++;
                @(negedge clk);
            end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check({pfx, " post-rst V_out"}, V_out[r], 256'(0));
            check({pfx, " post-rst in_ready"}, 256'(in_ready[r]), 256'(1));
            check({pfx, " post-rst busy"}, 256'(busy[r]), 256'(0));
            for (int c = 0; c < 80; c++) begin
                if (out_valid[r]) ov_seen++;
                @(negedge clk);
            end
            check({pfx, " aborted out_valid"}, 256'(ov_seen), 256'(0));
            send(r, 1'b0, BLK_ABC, 1'b0, lat, v);
            check({pfx, " post-rst first=0 digest"}, v, DIG_ABC);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
